// File: rtl/pong_input_cond_if.sv
// Player button and mode bundle between the raw register/pin side and the LCD pong controller.
// The master drives the raw inputs; the slave (the conditioner) drives the cleaned outputs.
interface pong_input_cond_if;
  logic [3:0] button_raw;
  logic [1:0] mode_raw;
  logic [3:0] button;
  logic [3:0] btn_press;
  logic [1:0] mode;
  logic       mode_changed;

  modport master (
    output button_raw,
    output mode_raw,
    input  button,
    input  btn_press,
    input  mode,
    input  mode_changed
  );

  modport slave (
    input  button_raw,
    input  mode_raw,
    output button,
    output btn_press,
    output mode,
    output mode_changed
  );
endinterface

// File: rtl/pong_input_cond.sv
// Conditions the raw pong buttons and the mode word before they reach the LCD pong controller.
// Each button is synchronised, debounced and pair-masked; mode is synchronised and skew-filtered.
module pong_input_cond #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int NUM_BTN         = 4
) (
  input  logic             TCLK,
  input  logic             nRESET,
  pong_input_cond_if.slave io
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_t;

  logic [NUM_BTN-1:0] btn_s1;
  logic [NUM_BTN-1:0] btn_s2;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] press_vec;
  logic [1:0]         m_s1;
  logic [1:0]         m_s2;
  logic [1:0]         mode_q;
  logic               mode_chg_q;

  always_ff @(posedge TCLK or negedge nRESET) begin
    if (!nRESET) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= io.button_raw;
      btn_s2 <= btn_s1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press;
    logic             press_nxt;

    always_ff @(posedge TCLK or negedge nRESET) begin
      if (!nRESET) begin
        state <= RELEASED;
        cnt   <= '0;
        press <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        press <= press_nxt;
      end
    end

    // The counter never wraps: reaching CNT_MAX always leaves the check state.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      case (state)
        RELEASED: begin
          if (btn_s2[i]) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = '0;
          end
        end
        PRESS_CHK: begin
          if (!btn_s2[i]) begin
            state_nxt = RELEASED;
          end else if (cnt == CNT_MAX) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s2[i]) begin
            state_nxt = RELEASE_CHK;
            cnt_nxt   = '0;
          end
        end
        RELEASE_CHK: begin
          if (btn_s2[i]) begin
            state_nxt = PRESSED;
          end else if (cnt == CNT_MAX) begin
            state_nxt = RELEASED;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign lvl[i]       = (state == PRESSED) || (state == RELEASE_CHK);
    assign press_vec[i] = press;
  end

  // Mode only moves once two consecutive synchronised samples agree, hiding bit skew.
  always_ff @(posedge TCLK or negedge nRESET) begin
    if (!nRESET) begin
      m_s1       <= 2'b00;
      m_s2       <= 2'b00;
      mode_q     <= 2'b00;
      mode_chg_q <= 1'b0;
    end else begin
      m_s1 <= io.mode_raw;
      m_s2 <= m_s1;
      if ((m_s2 == m_s1) && (m_s2 != mode_q)) begin
        mode_q     <= m_s2;
        mode_chg_q <= 1'b1;
      end else begin
        mode_chg_q <= 1'b0;
      end
    end
  end

  assign io.button       = {(&lvl[3:2]) ? 2'b00 : lvl[3:2],
                            (&lvl[1:0]) ? 2'b00 : lvl[1:0]};
  assign io.btn_press    = press_vec;
  assign io.mode         = mode_q;
  assign io.mode_changed = mode_chg_q;

endmodule

// File: tb/tb_pong_input_cond.sv
// Bench for pong_input_cond: directed scenarios plus randomised button/mode traffic,
// all compared against a run-length reference model of the debounce and mode filter.
module tb_pong_input_cond;
  localparam int D = 4;

  logic TCLK   = 1'b0;
  logic nRESET = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  pong_input_cond_if bus ();

  pong_input_cond #(
    .DEBOUNCE_CYCLES (D),
    .NUM_BTN         (4)
  ) dut (
    .TCLK   (TCLK),
    .nRESET (nRESET),
    .io     (bus)
  );

  always #5 TCLK = ~TCLK;

  // Model: a button level flips once D+1 consecutive synchronised samples disagree with it.
  logic [3:0] btn_hist[$];
  logic [1:0] mode_hist[$];
  logic [3:0] run_val;
  int         run_len[4];
  logic [3:0] m_lvl;
  logic [3:0] exp_press;
  logic [1:0] m_mode;
  logic       exp_chg;

  function automatic logic [3:0] mask_pairs(input logic [3:0] l);
    logic [3:0] r;
    r = l;
    if (l[1:0] == 2'b11) r[1:0] = 2'b00;
    if (l[3:2] == 2'b11) r[3:2] = 2'b00;
    return r;
  endfunction

  function automatic logic [10:0] expected_all();
    return {mask_pairs(m_lvl), exp_press, m_mode, exp_chg};
  endfunction

  task automatic model_reset();
    btn_hist  = '{4'b0000, 4'b0000};
    mode_hist = '{2'b00, 2'b00};
    run_val   = 4'b0000;
    m_lvl     = 4'b0000;
    exp_press = 4'b0000;
    m_mode    = 2'b00;
    exp_chg   = 1'b0;
    foreach (run_len[i]) run_len[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] seen;
    logic [1:0] ma;
    logic [1:0] mb;
    seen = btn_hist[1];
    ma   = mode_hist[0];
    mb   = mode_hist[1];
    for (int i = 0; i < 4; i++) begin
      if (seen[i] == run_val[i]) begin
        if (run_len[i] < D + 1) run_len[i]++;
      end else begin
        run_val[i] = seen[i];
        run_len[i] = 1;
      end
      exp_press[i] = 1'b0;
      if (run_len[i] == D + 1 && seen[i] != m_lvl[i]) begin
        m_lvl[i]     = seen[i];
        exp_press[i] = seen[i];
      end
    end
    exp_chg = 1'b0;
    if (ma == mb && mb != m_mode) begin
      m_mode  = mb;
      exp_chg = 1'b1;
    end
    btn_hist.push_front(bus.button_raw);
    void'(btn_hist.pop_back());
    mode_hist.push_front(bus.mode_raw);
    void'(mode_hist.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge TCLK or negedge nRESET);
      if (!nRESET) model_reset();
      else         model_edge();
    end
  end

  task automatic do_reset();
    nRESET = 1'b0;
    bus.button_raw = 4'b0000;
    bus.mode_raw   = 2'b00;
    repeat (2) @(negedge TCLK);
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    bus.button_raw = 4'b0000;
    bus.mode_raw   = 2'b00;
    #2 nRESET = 1'b0;
    #1 obs = {bus.button, bus.btn_press, bus.mode, bus.mode_changed};
    total++;
    if (obs !== 11'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs, 11'b0);
    end
    repeat (2) @(negedge TCLK);
    nRESET = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge TCLK);
      obs = {bus.button, bus.btn_press, bus.mode, bus.mode_changed};
      total++;
      if (obs !== 11'b0) begin
        bad++;
        $display("[TB] FAIL reset_release e%0d: got %b expected %b", e, obs, 11'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [10:0] obs;
    logic [10:0] dir;
    do_reset();
    bus.button_raw = 4'b0001;
    for (int e = 1; e <= 9; e++) begin
      @(negedge TCLK);
      obs = {bus.button, bus.btn_press, bus.mode, bus.mode_changed};
      dir = {(e >= 7) ? 4'b0001 : 4'b0000, (e == 7) ? 4'b0001 : 4'b0000, 2'b00, 1'b0};
      total++;
      if (obs !== dir) begin
        bad++;
        $display("[TB] FAIL clean_press e%0d: got %b expected %b", e, obs, dir);
      end
      total++;
      if (obs !== expected_all()) begin
        bad++;
        $display("[TB] FAIL clean_press_model e%0d: got %b expected %b", e, obs, expected_all());
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern[4];
    pattern = '{4'b0101, 4'b0001, 4'b0101, 4'b0001};
    for (int e = 0; e < 14; e++) begin
      if (e < 4) bus.button_raw = pattern[e];
      @(negedge TCLK);
      total++;
      if (bus.button[2] !== 1'b0 || bus.btn_press[2] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bounce e%0d: got button[2]=%b btn_press[2]=%b expected 0 0",
                 e, bus.button[2], bus.btn_press[2]);
      end
      total++;
      if ({bus.button, bus.btn_press, bus.mode, bus.mode_changed} !== expected_all()) begin
        bad++;
        $display("[TB] FAIL bounce_model e%0d: got %b expected %b", e,
                 {bus.button, bus.btn_press, bus.mode, bus.mode_changed}, expected_all());
      end
    end
  endtask

  task automatic test_conflict();
    logic [7:0] obs;
    logic [7:0] dir;
    do_reset();
    bus.button_raw = 4'b0011;
    for (int e = 1; e <= 10; e++) begin
      @(negedge TCLK);
      obs = {bus.button, bus.btn_press};
      dir = {4'b0000, (e == 7) ? 4'b0011 : 4'b0000};
      total++;
      if (obs !== dir) begin
        bad++;
        $display("[TB] FAIL conflict_press e%0d: got %b expected %b", e, obs, dir);
      end
    end
    bus.button_raw = 4'b0001;
    for (int e = 1; e <= 9; e++) begin
      @(negedge TCLK);
      obs = {bus.button, bus.btn_press};
      dir = {(e >= 7) ? 4'b0001 : 4'b0000, 4'b0000};
      total++;
      if (obs !== dir) begin
        bad++;
        $display("[TB] FAIL conflict_unmask e%0d: got %b expected %b", e, obs, dir);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    do_reset();
    bus.button_raw = 4'b1111;
    pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge TCLK);
      if (bus.btn_press == 4'b1111) pulses++;
      total++;
      if ({bus.button, bus.btn_press, bus.mode, bus.mode_changed} !== expected_all()) begin
        bad++;
        $display("[TB] FAIL simultaneous_model e%0d: got %b expected %b", e,
                 {bus.button, bus.btn_press, bus.mode, bus.mode_changed}, expected_all());
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("[TB] FAIL simultaneous_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_release();
    logic [7:0] dir;
    do_reset();
    bus.button_raw = 4'b0100;
    repeat (9) @(negedge TCLK);
    bus.button_raw = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      @(negedge TCLK);
      dir = {(e < 7) ? 4'b0100 : 4'b0000, 4'b0000};
      total++;
      if ({bus.button, bus.btn_press} !== dir) begin
        bad++;
        $display("[TB] FAIL release e%0d: got %b expected %b", e, {bus.button, bus.btn_press}, dir);
      end
    end
  endtask

  task automatic test_mode_skew();
    logic [2:0] dir;
    do_reset();
    bus.mode_raw = 2'b01;
    repeat (5) @(negedge TCLK);
    total++;
    if (bus.mode !== 2'b01) begin
      bad++;
      $display("[TB] FAIL mode_settle: got %b expected 01", bus.mode);
    end
    bus.mode_raw = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge TCLK);
      if (k == 1) bus.mode_raw = 2'b10;
      dir = {(k >= 4) ? 2'b10 : 2'b01, (k == 4) ? 1'b1 : 1'b0};
      total++;
      if ({bus.mode, bus.mode_changed} !== dir) begin
        bad++;
        $display("[TB] FAIL mode_skew k%0d: got %b expected %b", k, {bus.mode, bus.mode_changed}, dir);
      end
      total++;
      if ({bus.button, bus.btn_press, bus.mode, bus.mode_changed} !== expected_all()) begin
        bad++;
        $display("[TB] FAIL mode_skew_model k%0d: got %b expected %b", k,
                 {bus.button, bus.btn_press, bus.mode, bus.mode_changed}, expected_all());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    logic [10:0] dir;
    do_reset();
    bus.button_raw = 4'b1000;
    bus.mode_raw   = 2'b10;
    repeat (8) @(negedge TCLK);
    bus.button_raw = 4'b1001;
    repeat (5) @(negedge TCLK);
    #2 nRESET = 1'b0;
    #1 obs = {bus.button, bus.btn_press, bus.mode, bus.mode_changed};
    total++;
    if (obs !== 11'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got %b expected %b", obs, 11'b0);
    end
    repeat (2) @(negedge TCLK);
    nRESET = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge TCLK);
      obs = {bus.button, bus.btn_press, bus.mode, bus.mode_changed};
      dir = {(e >= 7) ? 4'b1001 : 4'b0000, (e == 7) ? 4'b1001 : 4'b0000,
             (e >= 3) ? 2'b10 : 2'b00, (e == 3) ? 1'b1 : 1'b0};
      total++;
      if (obs !== dir) begin
        bad++;
        $display("[TB] FAIL reset_mid_fresh e%0d: got %b expected %b", e, obs, dir);
      end
    end
  endtask

  task automatic test_random();
    int hold[4];
    do_reset();
    foreach (hold[i]) hold[i] = $urandom_range(1, 2 * D + 2);
    for (int c = 0; c < 600; c++) begin
      @(negedge TCLK);
      total++;
      if ({bus.button, bus.btn_press, bus.mode, bus.mode_changed} !== expected_all()) begin
        bad++;
        $display("[TB] FAIL random_model c%0d: got %b expected %b", c,
                 {bus.button, bus.btn_press, bus.mode, bus.mode_changed}, expected_all());
      end
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          bus.button_raw[i] = ~bus.button_raw[i];
          hold[i] = $urandom_range(1, 2 * D + 2);
        end
      end
      if ($urandom_range(0, 7) == 0) bus.mode_raw = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    bus.button_raw = 4'b0000;
    bus.mode_raw   = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_conflict();
    test_back_to_back();
    test_release();
    test_mode_skew();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
